// File: rtl/nes_gamepad_multi.sv
// nes_gamepad_multi: polls NUM_PADS serial NES/SNES gamepads over a shared latch/clock pair
// and publishes an atomic, active-high snapshot of every pad once per poll period.
//
// Ports:
//   i_clk            system clock
//   i_rst            asynchronous active-high reset
//   i_enable         allow new transactions to start
//   i_serial_data    per-pad serial data, low = pressed (bit p = pad p)
//   o_data_latch     pad latch/strobe
//   o_data_clock     pad shift clock, idles low
//   o_button_state   snapshot, 1 = pressed; pad p at [p*NUM_BITS +: NUM_BITS]
//   o_data_available one-cycle pulse when o_button_state updates
//   o_busy           high from latch rise through the DONE cycle
//   o_pressed_edge   newly pressed buttons (only when GAMEPAD_EDGE_EN is defined)
//
// Optional feature macro: GAMEPAD_EDGE_EN adds o_pressed_edge.

module nes_gamepad_multi #(
  parameter int unsigned CLK_FREQ_HZ    = 27000000,
  parameter int unsigned POLL_HZ        = 60,
  parameter int unsigned HALF_PERIOD_US = 6,
  parameter int unsigned NUM_BITS       = 8,
  parameter int unsigned NUM_PADS       = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_enable,
  input  logic [NUM_PADS-1:0]          i_serial_data,
  output logic                         o_data_latch,
  output logic                         o_data_clock,
  output logic [NUM_PADS*NUM_BITS-1:0] o_button_state,
  output logic                         o_data_available,
`ifdef GAMEPAD_EDGE_EN
  output logic [NUM_PADS*NUM_BITS-1:0] o_pressed_edge,
`endif
  output logic                         o_busy
);

  localparam int unsigned PollCyc = CLK_FREQ_HZ / POLL_HZ;
  localparam int unsigned H       = CLK_FREQ_HZ / 1000000 * HALF_PERIOD_US;
  localparam int unsigned PW      = (H < 1) ? 1 : $clog2(2 * H);
  localparam int unsigned CW      = (PollCyc < 2) ? 1 : $clog2(PollCyc);
  localparam int unsigned BW      = (NUM_BITS < 2) ? 1 : $clog2(NUM_BITS);
  localparam int unsigned W       = NUM_PADS * NUM_BITS;

  if (H < 1) begin : g_bad_half_period
    $error("nes_gamepad_multi: half period is shorter than one clock cycle");
  end
  if (NUM_BITS < 2 || NUM_BITS > 32) begin : g_bad_num_bits
    $error("nes_gamepad_multi: NUM_BITS must be 2..32");
  end
  if (NUM_PADS < 1 || NUM_PADS > 4) begin : g_bad_num_pads
    $error("nes_gamepad_multi: NUM_PADS must be 1..4");
  end

  typedef enum logic [2:0] {StIdle, StLatch, StLow, StHigh, StDone} state_e;

  state_e          state_q;
  logic [CW-1:0]   poll_q;
  logic            tick_q;
  logic [PW-1:0]   phase_q;
  logic [BW-1:0]   bit_q;
  logic [W-1:0]    shift_q;
  logic [W-1:0]    shift_d;
  logic            phase_last;
  logic            sample;

  // LATCH lasts 2H cycles, LOW and HIGH last H cycles each.
  always_comb begin
    if (state_q == StLatch) phase_last = (phase_q == PW'(2 * H - 1));
    else                    phase_last = (phase_q == PW'(H - 1));
  end

  // Sample on the last LOW cycle; DONE publishes shift_d so the final bit is included.
  always_comb begin
    shift_d = shift_q;
    sample  = (state_q == StLow) && phase_last;
    if (sample) begin
      for (int p = 0; p < int'(NUM_PADS); p++) begin
        shift_d[p * int'(NUM_BITS) + int'(bit_q)] = ~i_serial_data[p];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q          <= StIdle;
      poll_q           <= '0;
      tick_q           <= 1'b0;
      phase_q          <= '0;
      bit_q            <= '0;
      shift_q          <= '0;
      o_data_latch     <= 1'b0;
      o_data_clock     <= 1'b0;
      o_button_state   <= '0;
      o_data_available <= 1'b0;
      o_busy           <= 1'b0;
`ifdef GAMEPAD_EDGE_EN
      o_pressed_edge   <= '0;
`endif
    end else begin
      poll_q           <= (poll_q == CW'(PollCyc - 1)) ? '0 : poll_q + 1'b1;
      tick_q           <= (poll_q == CW'(PollCyc - 1));
      shift_q          <= shift_d;
      o_data_available <= 1'b0;

      unique case (state_q)
        StIdle: begin
          phase_q <= '0;
          // Ticks arriving while busy or disabled are simply dropped.
          if (tick_q && i_enable) begin
            state_q      <= StLatch;
            o_data_latch <= 1'b1;
            o_busy       <= 1'b1;
          end
        end
        StLatch: begin
          if (phase_last) begin
            phase_q      <= '0;
            o_data_latch <= 1'b0;
            state_q      <= StLow;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StLow: begin
          if (phase_last) begin
            phase_q <= '0;
            if (bit_q == BW'(NUM_BITS - 1)) begin
              state_q          <= StDone;
              o_button_state   <= shift_d;
              o_data_available <= 1'b1;
`ifdef GAMEPAD_EDGE_EN
              o_pressed_edge   <= shift_d & ~o_button_state;
`endif
            end else begin
              state_q      <= StHigh;
              o_data_clock <= 1'b1;
            end
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StHigh: begin
          if (phase_last) begin
            phase_q      <= '0;
            o_data_clock <= 1'b0;
            bit_q        <= bit_q + 1'b1;
            state_q      <= StLow;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        StDone: begin
          bit_q   <= '0;
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_nes_gamepad_multi.sv
module tb_nes_gamepad_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;

  logic [0:0]  sd8;
  logic        latch8, clk8, busy8, avail8;
  logic [7:0]  btn8;
  logic [1:0]  sd16;
  logic        latch16, clk16, busy16, avail16;
  logic [31:0] btn16;
`ifdef GAMEPAD_EDGE_EN
  logic [7:0]  edge8;
  logic [31:0] edge16;
`endif

  always #5 clk = ~clk;

  nes_gamepad_multi #(
    .CLK_FREQ_HZ(1000000), .POLL_HZ(10000), .HALF_PERIOD_US(2), .NUM_BITS(8), .NUM_PADS(1)
  ) u_dut8 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (en),
    .i_serial_data    (sd8),
    .o_data_latch     (latch8),
    .o_data_clock     (clk8),
    .o_button_state   (btn8),
    .o_data_available (avail8),
`ifdef GAMEPAD_EDGE_EN
    .o_pressed_edge   (edge8),
`endif
    .o_busy           (busy8)
  );

  nes_gamepad_multi #(
    .CLK_FREQ_HZ(1000000), .POLL_HZ(10000), .HALF_PERIOD_US(2), .NUM_BITS(16), .NUM_PADS(2)
  ) u_dut16 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (en),
    .i_serial_data    (sd16),
    .o_data_latch     (latch16),
    .o_data_clock     (clk16),
    .o_button_state   (btn16),
    .o_data_available (avail16),
`ifdef GAMEPAD_EDGE_EN
    .o_pressed_edge   (edge16),
`endif
    .o_busy           (busy16)
  );

  // Pad models: raw bits are active-low, bit 0 presented after latch, advance on clock rise.
  logic [7:0]  raw8    = 8'hFF;
  logic [15:0] raw16_0 = 16'hFFFE;
  logic [15:0] raw16_1 = 16'h7FFF;
  int          idx8    = 0;
  int          idx16   = 0;

  always @(posedge latch8)  idx8  <= 0;
  always @(posedge clk8)    idx8  <= idx8 + 1;
  always @(posedge latch16) idx16 <= 0;
  always @(posedge clk16)   idx16 <= idx16 + 1;

  assign sd8[0]  = (idx8 < 8)   ? raw8[idx8[2:0]]     : 1'b1;
  assign sd16[0] = (idx16 < 16) ? raw16_0[idx16[3:0]] : 1'b1;
  assign sd16[1] = (idx16 < 16) ? raw16_1[idx16[3:0]] : 1'b1;

  // Cycle counter and transaction monitors.
  int n_cyc = 0;
  always @(posedge clk) n_cyc <= n_cyc + 1;

  logic latch_p = 1'b0, clk_p = 1'b0, latch16_p = 1'b0, clk16_p = 1'b0, avail_p = 1'b0;
  int rise_cyc = 0, rise_cnt = 0, latch_len = 0, busy_len = 0, pulses8 = 0;
  int clk_hlen = 0, clk_bad = 0, avail8_cnt = 0, avail8_cyc = 0, avail_bad = 0;
  int rise16_cyc = 0, pulses16 = 0, avail16_cnt = 0, avail16_cyc = 0;

  always @(negedge clk) begin
    latch_p   <= latch8;
    clk_p     <= clk8;
    latch16_p <= latch16;
    clk16_p   <= clk16;
    avail_p   <= avail8;
    if (latch8 && !latch_p) begin
      rise_cyc  <= n_cyc;
      rise_cnt  <= rise_cnt + 1;
      latch_len <= 1;
      busy_len  <= int'(busy8);
      pulses8   <= 0;
      clk_bad   <= 0;
    end else begin
      latch_len <= latch_len + int'(latch8);
      busy_len  <= busy_len + int'(busy8);
      if (clk8 && !clk_p) pulses8 <= pulses8 + 1;
      if (!clk8 && clk_p && clk_hlen != 2) clk_bad <= clk_bad + 1;
    end
    clk_hlen <= clk8 ? clk_hlen + 1 : 0;
    if (avail8) begin
      avail8_cnt <= avail8_cnt + 1;
      avail8_cyc <= n_cyc;
      if (avail_p) avail_bad <= avail_bad + 1;
    end
    if (latch16 && !latch16_p) begin
      rise16_cyc <= n_cyc;
      pulses16   <= 0;
    end else if (clk16 && !clk16_p) begin
      pulses16 <= pulses16 + 1;
    end
    if (avail16) begin
      avail16_cnt <= avail16_cnt + 1;
      avail16_cyc <= n_cyc;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_rise(input int budget, input string tag);
    int start;
    start = rise_cnt;
    for (int i = 0; i < budget && rise_cnt == start; i++) step();
    check(tag, 32'(rise_cnt != start), 32'd1);
  endtask

  task automatic wait_avail(input int budget, input string tag);
    int start;
    start = avail8_cnt;
    for (int i = 0; i < budget && avail8_cnt == start; i++) step();
    check(tag, 32'(avail8_cnt != start), 32'd1);
  endtask

  int r0, r2, rise1, rise2, rise3, rc, ac;

  initial begin
    raw8 = ~8'h09;
    repeat (3) step();
    check("reset_latch", 32'(latch8), 32'd0);
    check("reset_busy", 32'(busy8), 32'd0);
    check("reset_avail", 32'(avail8), 32'd0);
    check("reset_button", 32'(btn8), 32'd0);
    rst = 1'b0;
    r0  = n_cyc;

    // First transaction: NES 1 pad and SNES 2 pads side by side.
    wait_rise(200, "first_latch_seen");
    rise1 = rise_cyc;
    check("first_latch_delay", 32'(rise1 - r0), 32'd101);
    check("latch16_same_cycle", 32'(rise16_cyc - r0), 32'd101);
    wait_avail(100, "avail1_seen");
    check("latch_len", 32'(latch_len), 32'd4);
    check("clk_pulses8", 32'(pulses8), 32'd7);
    check("clk_high_len", 32'(clk_bad), 32'd0);
    check("button8_t1", 32'(btn8), 32'h09);
    check("avail8_latency", 32'(avail8_cyc - rise1), 32'd34);
    step();
    check("avail_one_cycle", 32'(avail_bad), 32'd0);
    check("busy_len", 32'(busy_len), 32'd35);
`ifdef GAMEPAD_EDGE_EN
    check("edge8_t1", 32'(edge8), 32'h09);
`endif
    for (int i = 0; i < 60 && avail16_cnt == 0; i++) step();
    check("avail16_seen", 32'(avail16_cnt), 32'd1);
    check("button16_t1", btn16, 32'h8000_0001);
    check("clk_pulses16", 32'(pulses16), 32'd15);
    check("avail16_latency", 32'(avail16_cyc - rise16_cyc), 32'd66);
`ifdef GAMEPAD_EDGE_EN
    check("edge16_t1", edge16, 32'h8000_0001);
`endif

    // Second transaction, with i_enable dropped mid-way and held for three polls.
    raw8 = ~8'hA5;
    wait_rise(150, "second_latch_seen");
    rise2 = rise_cyc;
    check("poll_period", 32'(rise2 - rise1), 32'd100);
    repeat (10) step();
    en = 1'b0;
    wait_avail(100, "avail2_seen");
    check("button8_t2", 32'(btn8), 32'hA5);
`ifdef GAMEPAD_EDGE_EN
    check("edge8_t2", 32'(edge8), 32'hA4);
`endif
    rc = rise_cnt;
    while (n_cyc < rise2 + 350) step();
    check("no_latch_disabled", 32'(rise_cnt), 32'(rc));
    en = 1'b1;
    wait_rise(100, "reenable_latch_seen");
    rise3 = rise_cyc;
    check("reenable_latch", 32'(rise3 - rise2), 32'd400);

    // Reset during the HIGH phase of bit 4.
    raw8 = 8'h00;
    while (n_cyc < rise3 + 22) step();
    check("in_high_bit4", 32'(clk8), 32'd1);
    check("pulses_before_rst", 32'(pulses8), 32'd5);
    ac  = avail8_cnt;
    rst = 1'b1;
    #1;
    check("rst_latch", 32'(latch8), 32'd0);
    check("rst_clock", 32'(clk8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_button", 32'(btn8), 32'd0);
`ifdef GAMEPAD_EDGE_EN
    check("rst_edge", 32'(edge8), 32'd0);
`endif
    repeat (3) step();
    rst  = 1'b0;
    r2   = n_cyc;
    raw8 = ~8'h01;
    wait_rise(150, "post_rst_latch_seen");
    check("post_rst_latch", 32'(rise_cyc - r2), 32'd101);
    check("no_partial_avail", 32'(avail8_cnt), 32'(ac));

    // Snapshot sequence 01 -> 03 -> 02.
    wait_avail(100, "avail_a_seen");
    check("button8_a", 32'(btn8), 32'h01);
`ifdef GAMEPAD_EDGE_EN
    check("edge8_a", 32'(edge8), 32'h01);
`endif
    raw8 = ~8'h03;
    wait_avail(150, "avail_b_seen");
    check("button8_b", 32'(btn8), 32'h03);
`ifdef GAMEPAD_EDGE_EN
    check("edge8_b", 32'(edge8), 32'h02);
`endif
    raw8 = ~8'h02;
    wait_avail(150, "avail_c_seen");
    check("button8_c", 32'(btn8), 32'h02);
`ifdef GAMEPAD_EDGE_EN
    check("edge8_c", 32'(edge8), 32'h00);
`endif
    repeat (20) step();
    check("button8_hold", 32'(btn8), 32'h02);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/nes_gamepad_multi.md
Name: nes_gamepad_multi

Overview:
- Parametrised successor to the single-pad NES reader. Polls up to NUM_PADS serial gamepads (NES 8-bit or SNES 16-bit) over a shared latch/clock pair with per-pad data lines.
- All timing comes from clock-enable counters on the single system clock. No derived clocks.
- Sits between the board gamepad pins and the APU/CPU joypad registers. Delivers an atomic, active-high snapshot of all pads at POLL_HZ.

Parameters:
- CLK_FREQ_HZ, 27000000, system clock frequency.
- POLL_HZ, 60, transaction start rate. POLL_CYC = CLK_FREQ_HZ/POLL_HZ.
- HALF_PERIOD_US, 6, half period of the pad clock. H = CLK_FREQ_HZ/1000000*HALF_PERIOD_US; elaboration error if H < 1.
- NUM_BITS, 8, bits per pad: 8 = NES, 16 = SNES. Range 2..32.
- NUM_PADS, 2, number of pads. Range 1..4.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_enable  in  1  allow new transactions to start.
- i_serial_data  in  NUM_PADS  raw pad data. Low = pressed. Bit p belongs to pad p.
- o_data_latch  out  1  pad latch/strobe.
- o_data_clock  out  1  pad shift clock. Idles low; pads shift on its rising edge.
- o_button_state  out  NUM_PADS*NUM_BITS  snapshot, 1 = pressed. Pad p occupies [p*NUM_BITS +: NUM_BITS]; first bit shifted out (A/B) lands at bit 0.
- o_data_available  out  1  one-cycle pulse when o_button_state updates.
- o_busy  out  1  high from latch rise until the DONE cycle inclusive.

Behaviour:
- Reset (async, any state): state = IDLE; poll counter = 0; bit counter = 0; phase counter = 0; shift registers = 0. All outputs 0, including o_button_state. On reset mid-transaction the latch and clock drop immediately and no partial data is published.
- Poll counter: free-runs 0..POLL_CYC-1 and wraps. Tick = counter at POLL_CYC-1. Runs regardless of i_enable. First tick is POLL_CYC cycles after reset release.
- Tick handling: a tick in IDLE with i_enable=1 starts a transaction on the next cycle. A tick while busy or with i_enable=0 is dropped, not queued. Deasserting i_enable mid-transaction does not abort it.
- States, each lasting a whole number of H cycles counted by the phase counter:
  - IDLE: latch = 0, clock = 0.
  - LATCH: latch = 1, clock = 0, 2H cycles. Then LOW.
  - LOW: latch = 0, clock = 0, H cycles. On the last cycle, sample ~i_serial_data into each pad's shift register at position bit_cnt. If bit_cnt = NUM_BITS-1 go to DONE, else go to HIGH.
  - HIGH: clock = 1, H cycles. Then bit_cnt += 1 and return to LOW.
  - DONE: one cycle. o_button_state <= all shift registers (atomic update of all pads). o_data_available = 1. Clear bit_cnt. Go to IDLE.
- Clock pulses: exactly NUM_BITS-1 rising edges per transaction. Bit 0 is valid straight after latch.
- Latency: if latch rises at cycle T, DONE and the o_data_available pulse occur at T + (2*NUM_BITS+1)*H.
- Registered outputs: latch, clock, busy and available are registered with no glitches.
- Widths: the poll counter is clog2(POLL_CYC) bits and the phase counter is clog2(2H) bits, so no overflow is possible.
- o_button_state holds its value between DONE cycles.

Optional Feature:
- Macro: GAMEPAD_EDGE_EN.
- With the macro defined:
  - Adds output o_pressed_edge, NUM_PADS*NUM_BITS wide.
  - In the DONE cycle it is set to new_snapshot & ~old o_button_state and holds until the next DONE.
  - Reset value is 0.
  - The first transaction after reset compares against the all-zero reset snapshot.
- Without the macro: the port and its logic are absent and all other behaviour is identical.

Test Plan:
All scenarios use CLK_FREQ_HZ=1000000, HALF_PERIOD_US=2 (H=2), POLL_HZ=10000 (POLL_CYC=100).
1. NUM_PADS=1, NUM_BITS=8. Pad model outputs raw bits 0 and 3 low.
   -> latch high exactly 4 cycles; 7 clock pulses, each 2 cycles high; o_button_state=8'h09; o_data_available high exactly 1 cycle, 34 cycles after latch rise.
2. NUM_PADS=2, NUM_BITS=16. Pad0 presses bit 0, pad1 presses bit 15.
   -> 15 clock pulses; o_button_state=32'h8000_0001; available 66 cycles after latch rise.
3. Release reset and track cycles.
   -> first latch rise 101 cycles after release; next latch rise exactly 100 cycles later; o_busy high 35 cycles per transaction.
4. Assert i_rst during the HIGH phase of bit 4.
   -> latch, clock, busy and o_button_state all 0 within the same cycle; no available pulse; next latch 101 cycles after release.
5. Drop i_enable mid-transaction and hold it low for 3 polls, then raise it.
   -> current transaction completes with a valid snapshot; no latch during the 3 periods; next latch on the first tick after re-enable.
6. GAMEPAD_EDGE_EN defined. Snapshot goes 8'h01 then 8'h03 then 8'h02.
   -> o_pressed_edge = 8'h01, then 8'h02, then 8'h00.
